// File: rtl/write_stream_ahb_master.sv
// -----------------------------------------------------------------------------
// write_stream_ahb_master
//
// Accepts a byte stream (valid/ready), packs it little-endian into 32-bit
// words held in a small word FIFO, and drains the FIFO as AHB-Lite
// incrementing write transfers starting at {ADDR_HIGH, ADDR_LOW} for
// BUFFER_LENGTH words. Sits behind the Switch arbiter as one more master.
//
// Ports
//   HCLK, HRESETn          clock, synchronous active-low reset
//   i_WriteSystemStart     one-cycle start pulse, honoured only in IDLE
//   i_RCC_DMA_ADDR_HIGH/LOW base address (word aligned on capture)
//   i_RCC_BUFFER_LENGTH    job length in words (0 = empty job)
//   i_byte/_valid, o_byte_ready  byte input stream
//   HREADY                 transfer-complete from the Switch
//   o_HTRANS               2'b00 IDLE, 2'b01 BUSY, 2'b10 NONSEQ, 2'b11 SEQ
//   mem_WR_addr            address-phase address
//   mem_write_flag         address phase of a write is valid
//   HWDATA_toMem           write data, one cycle after the accepted address
//   O_Bytes_Counter        bytes accepted in the current job (saturating)
//   slave_done             one-cycle pulse after the last data phase
// -----------------------------------------------------------------------------
module write_stream_ahb_master #(
  parameter int FIFO_DEPTH    = 4,
  parameter int BOUNDARY_BITS = 10
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        i_WriteSystemStart,
  input  logic [15:0] i_RCC_DMA_ADDR_HIGH,
  input  logic [15:0] i_RCC_DMA_ADDR_LOW,
  input  logic [5:0]  i_RCC_BUFFER_LENGTH,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  input  logic        HREADY,
  output logic [1:0]  o_HTRANS,
  output logic [31:0] mem_WR_addr,
  output logic        mem_write_flag,
  output logic [31:0] HWDATA_toMem,
  output logic [15:0] O_Bytes_Counter,
  output logic        slave_done
);

  localparam int              PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  // WAIT doubles as the "armed, nothing issued yet" state: it shows IDLE on
  // the bus until the first beat, and BUSY once a burst is under way.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ADDR,
    S_LAST,
    S_DONE
  } state_t;

  state_t                         state_q,    state_d;
  logic [31:0]                    addr_q,     addr_d;
  logic [5:0]                     len_q,      len_d;
  logic [5:0]                     issued_q,   issued_d;
  logic [5:0]                     packed_q,   packed_d;
  logic [1:0]                     byte_idx_q, byte_idx_d;
  logic [23:0]                    pack_q,     pack_d;
  logic [PTR_W-1:0]               wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]               rd_ptr_q,   rd_ptr_d;
  logic [PTR_W:0]                 count_q,    count_d;
  logic [1:0]                     htrans_q,   htrans_d;
  logic                           wr_flag_q,  wr_flag_d;
  logic [31:0]                    hwdata_q,   hwdata_d;
  logic [15:0]                    bytes_q,    bytes_d;
  logic                           done_q,     done_d;
  logic [FIFO_DEPTH-1:0][31:0]    fifo_q;

  logic fifo_full;
  logic pop;
  logic byte_ready;
  logic accept;
  logic push;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    packed_d   = packed_q;
    byte_idx_d = byte_idx_q;
    pack_d     = pack_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    hwdata_d   = hwdata_q;
    bytes_d    = bytes_q;
    done_d     = 1'b0;
    htrans_d   = HT_IDLE;
    wr_flag_d  = 1'b0;

    fifo_full  = (count_q == FIFO_FULL);
    // An address phase completes (and frees a slot) whenever we are in ADDR
    // and the slave is ready; that slot may be refilled in the same cycle.
    pop        = (state_q == S_ADDR) && HREADY;
    byte_ready = (state_q inside {S_WAIT, S_ADDR, S_LAST}) &&
                 (packed_q < len_q) && (!fifo_full || pop);
    accept     = byte_ready && i_byte_valid;
    push       = accept && (byte_idx_q == 2'd3);

    // Byte packer: bytes 0..2 are staged, the 4th completes the word.
    if (accept) begin
      byte_idx_d = byte_idx_q + 2'd1;
      if (bytes_q != 16'hFFFF) bytes_d = bytes_q + 16'd1;
      case (byte_idx_q)
        2'd0:    pack_d[7:0]   = i_byte;
        2'd1:    pack_d[15:8]  = i_byte;
        2'd2:    pack_d[23:16] = i_byte;
        default: ;
      endcase
    end

    if (push) begin
      packed_d = packed_q + 6'd1;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      hwdata_d = fifo_q[rd_ptr_q];
      addr_d   = addr_q + 32'd4;
      issued_d = issued_q + 6'd1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (i_WriteSystemStart) begin
          addr_d     = {i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW[15:2], 2'b00};
          len_d      = i_RCC_BUFFER_LENGTH;
          issued_d   = '0;
          packed_d   = '0;
          byte_idx_d = '0;
          bytes_d    = '0;
          if (i_RCC_BUFFER_LENGTH == 6'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (count_d != '0) state_d = S_ADDR;
      end
      S_ADDR: begin
        // HREADY low holds everything: no pop, so addr/issued stay put.
        if (HREADY) begin
          if (issued_d == len_q)   state_d = S_LAST;
          else if (count_d != '0)  state_d = S_ADDR;
          else                     state_d = S_WAIT;
        end
      end
      S_LAST: begin
        // Final data phase is on the bus; finish once the slave takes it.
        if (HREADY) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Bus controls are registered from the next state so they line up with
    // the cycle in which that state is live.
    case (state_d)
      S_ADDR: begin
        wr_flag_d = 1'b1;
        htrans_d  = (issued_d == 6'd0 || addr_d[BOUNDARY_BITS-1:0] == '0)
                    ? HT_NONSEQ : HT_SEQ;
      end
      S_WAIT:  htrans_d = (issued_d == 6'd0) ? HT_IDLE : HT_BUSY;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      packed_q   <= '0;
      byte_idx_q <= '0;
      pack_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      htrans_q   <= HT_IDLE;
      wr_flag_q  <= 1'b0;
      hwdata_q   <= '0;
      bytes_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      packed_q   <= packed_d;
      byte_idx_q <= byte_idx_d;
      pack_q     <= pack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      htrans_q   <= htrans_d;
      wr_flag_q  <= wr_flag_d;
      hwdata_q   <= hwdata_d;
      bytes_q    <= bytes_d;
      done_q     <= done_d;
    end
  end

  // Word storage needs no reset: the pointers define what is valid.
  always_ff @(posedge HCLK) begin
    if (push) fifo_q[wr_ptr_q] <= {i_byte, pack_q};
  end

  assign o_byte_ready    = byte_ready;
  assign o_HTRANS        = htrans_q;
  assign mem_WR_addr     = addr_q;
  assign mem_write_flag  = wr_flag_q;
  assign HWDATA_toMem    = hwdata_q;
  assign O_Bytes_Counter = bytes_q;
  assign slave_done      = done_q;

endmodule

// File: doc/write_stream_ahb_master.md
Name: write_stream_ahb_master

Overview:
- Write-direction counterpart of the read system's serializer path.
- Accepts a byte stream with a valid/ready handshake and packs it little-endian into 32-bit words in a small word FIFO.
- Issues AHB-Lite incrementing write transfers to external memory at {RCC_DMA_ADDR_HIGH, RCC_DMA_ADDR_LOW} for RCC_BUFFER_LENGTH words.
- Sits behind the Switch arbiter, as one more AHB master.

Parameters:
- FIFO_DEPTH, 4, depth of the packed-word FIFO in 32-bit words (power of 2, ≥2).
- BOUNDARY_BITS, 10, address bits defining the burst boundary; 10 = 1 KB, at which a new NONSEQ is forced.

Ports:
- HCLK  in  1  system clock; all logic on rising edge.
- HRESETn  in  1  synchronous active-low reset.
- i_WriteSystemStart  in  1  one-cycle start pulse; ignored unless in IDLE.
- i_RCC_DMA_ADDR_HIGH  in  16  base address [31:16], sampled at start.
- i_RCC_DMA_ADDR_LOW  in  16  base address [15:0], sampled at start; [1:0] forced to 0.
- i_RCC_BUFFER_LENGTH  in  6  transfer length in words, sampled at start; 0 = empty job.
- i_byte  in  8  input data byte.
- i_byte_valid  in  1  i_byte valid.
- o_byte_ready  out  1  byte accepted on cycle where valid && ready.
- HREADY  in  1  from Switch; 1 = current address/data phase completes this cycle.
- o_HTRANS  out  HTRANS_state  IDLE/BUSY/NONSEQ/SEQ.
- mem_WR_addr  out  32  address-phase address.
- mem_write_flag  out  1  address phase of a write transfer is valid.
- HWDATA_toMem  out  32  write data, valid in data phase (one cycle after accepted address phase).
- O_Bytes_Counter  out  16  bytes accepted in the current job.
- slave_done  out  1  one-cycle pulse when the last data phase completes.

Behaviour:
- Reset (HRESETn low at a clock edge): state IDLE; FIFO and packer flushed.
- Reset values of all outputs: o_byte_ready=0, o_HTRANS=IDLE, mem_write_flag=0, mem_WR_addr=0, HWDATA_toMem=0, O_Bytes_Counter=0, slave_done=0.
- A reset mid-burst abandons the job immediately; no further transfers are issued.
- Start:
  - In IDLE, i_WriteSystemStart=1 latches addr={HIGH,LOW[15:2],2'b00} and len=i_RCC_BUFFER_LENGTH, and clears O_Bytes_Counter.
  - len=0: slave_done pulses the next cycle and state returns to IDLE; no bytes accepted.
- Packing:
  - Byte k of a word goes to bits [8k+7:8k], k=0..3.
  - The 4th byte pushes the word into the FIFO in the same cycle it is accepted.
  - O_Bytes_Counter increments by 1 per accepted byte and saturates at 0xFFFF.
- o_byte_ready=1 only when all of the following hold:
  - state is not IDLE or DONE;
  - words packed < len;
  - the FIFO is not full, or a pop occurs in the same cycle.
  - Bytes beyond len*4 are never accepted.
- FIFO: push and pop in the same cycle are allowed; occupancy is unchanged.
- States:
  - IDLE: o_HTRANS=IDLE.
  - ADDR: FIFO non-empty.
    - o_HTRANS=NONSEQ for the first beat, after any BUSY→restart across a boundary, or when addr[BOUNDARY_BITS-1:0]==0. Otherwise SEQ.
    - mem_write_flag=1 and mem_WR_addr=addr.
    - When HREADY=1: pop the FIFO, register the word to HWDATA_toMem for the next cycle, addr+=4 (mod 2^32, wraps 0xFFFFFFFC→0), issued++.
    - When HREADY=0: address, HTRANS and data are held stable.
  - WAIT: more words are due but the FIFO is empty.
    - o_HTRANS=BUSY, mem_write_flag=0.
    - HWDATA_toMem holds the previous beat's data until HREADY=1.
    - Returns to ADDR with SEQ when the FIFO becomes non-empty.
  - LAST: issued==len.
    - o_HTRANS=IDLE, mem_write_flag=0, HWDATA_toMem is the final word.
    - On HREADY=1: slave_done=1 next cycle, go to DONE.
  - DONE: one cycle, then IDLE.
- Latency:
  - FIFO-push → first address phase: 1 cycle.
  - Address-phase accept → data phase: 1 cycle.
  - Back-to-back SEQ beats at 1 word/cycle when the FIFO is fed and HREADY=1.
- Simultaneous start and byte_valid in IDLE: the byte is not accepted (ready=0 that cycle).
- Start while not IDLE: ignored; the latched parameters are unchanged.

Test Plan:
- Start, addr 0x0001_0000, len=2; bytes 0x11..0x18 back-to-back, HREADY=1 → NONSEQ@0x00010000 then SEQ@0x00010004; HWDATA 0x14131211 then 0x18171615; slave_done 1 cycle after last data; O_Bytes_Counter=8.
- Same job with HREADY=0 for 3 cycles during the second address phase → addr/HTRANS/data held stable; no duplicate write; final memory identical.
- len=4, byte stream stalls 5 cycles after word 1 → o_HTRANS=BUSY during the stall, then SEQ resumes; 4 writes total.
- Base 0x0000_03F8, len=4 → beats at 0x3F8 (NONSEQ), 0x3FC (SEQ), 0x400 (NONSEQ), 0x404 (SEQ).
- len=1 with 8 bytes offered → only 4 accepted; o_byte_ready=0 afterwards; O_Bytes_Counter=4.
- Assert HRESETn=0 mid-burst after 2 of 6 beats → next cycle all outputs at reset values; a new start with len=0 gives slave_done one cycle later.
